// File: rtl/jmb_stream_pkg.sv
// Shared definitions for the pixel stream source: FSM state encoding,
// a width helper and the default raster address width.
package jmb_stream_pkg;

  typedef logic [1:0] state_t;

  localparam state_t st_idle   = 2'd0;
  localparam state_t st_stream = 2'd1;
  localparam state_t st_hblank = 2'd2;
  localparam state_t st_finish = 2'd3;

  // Bits needed to index n items; never returns less than 1 so a
  // degenerate count still yields a legal vector width.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int default_addr_w = clog2(10 * 10);

endpackage

// File: rtl/jmb_pixel_stream_src_if.sv
// Frame-memory read port and pixel output stream of jmb_pixel_stream_src.
interface jmb_pixel_stream_src_if import jmb_stream_pkg::*; #(
  parameter int pixel_width = 8,
  parameter int addr_w      = default_addr_w
) ();

  logic                   mem_rd_en;
  logic [addr_w-1:0]      mem_addr;
  logic [pixel_width-1:0] mem_data;

  // Stream handshake: a pixel moves on every cycle where enable && out_ready.
  // While enable is high and out_ready low, data/sof/eol hold their values
  // and enable stays high; out_ready may change freely at any time.
  logic                   out_ready;
  logic                   enable;
  logic [pixel_width-1:0] data;
  logic                   sof;
  logic                   eol;

  modport master (
    output mem_rd_en, mem_addr, enable, data, sof, eol,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, enable, data, sof, eol,
    output mem_data, out_ready
  );

endinterface

// File: rtl/jmb_skid_fifo2.sv
// Two-entry FIFO with a registered head; absorbs read data that is still
// in flight when the downstream consumer stalls.
module jmb_skid_fifo2 #(
  parameter int width = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  logic [width-1:0] slot0;
  logic [width-1:0] slot1;
  logic [1:0]       cnt;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= push_data;
          else             slot1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = slot0;
  assign valid = (cnt != 2'd0);
  assign count = cnt;

endmodule

// File: rtl/jmb_pixel_stream_src.sv
// Reads one raster frame from frame memory and streams it out with
// sof/eol framing, per-line horizontal blanking and a done pulse.
module jmb_pixel_stream_src import jmb_stream_pkg::*; #(
  parameter int pixel_width  = 8,
  parameter int image_width  = 10,
  parameter int image_height = 10,
  parameter int hblank       = 2
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   start,
  output logic   busy,
  output logic   done,
  output state_t state_dbg,
  jmb_pixel_stream_src_if.master bus
);

  localparam int total  = image_width * image_height;
  localparam int addr_w = clog2(total);
  localparam int col_w  = clog2(image_width);
  localparam int line_w = clog2(image_height);
  localparam int hb_w   = clog2(hblank + 1);

  localparam logic [addr_w-1:0] last_addr = addr_w'(total - 1);
  localparam logic [col_w-1:0]  last_col  = col_w'(image_width - 1);
  localparam logic [line_w-1:0] last_line = line_w'(image_height - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [addr_w-1:0]      rd_addr;
  logic                   rd_done;
  logic [col_w-1:0]       rd_col;
  logic [line_w-1:0]      rd_line;
  logic                   in_flight;
  logic [1:0]             in_flight_tag;
  logic [line_w-1:0]      out_line;
  logic [hb_w-1:0]        hb_cnt;
  logic [1:0]             fifo_count;
  logic                   fifo_valid;
  logic [pixel_width+1:0] fifo_head;
  logic [2:0]             occupancy;
  logic                   issue;
  logic                   xfer;
  logic                   xfer_eol;

  // FIFO entry layout: {sof, eol, pixel}
  jmb_skid_fifo2 #(.width(pixel_width + 2)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (in_flight),
    .push_data ({in_flight_tag, bus.mem_data}),
    .pop       (xfer),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign bus.enable = (state == st_stream) && fifo_valid;
  assign xfer       = bus.enable && bus.out_ready;
  assign xfer_eol   = fifo_head[pixel_width];

  // Credit counts the slot freed by this cycle's pop so a full-rate stream
  // keeps one entry buffered and one read in flight. The first read goes out
  // in the start cycle itself, which puts the first pixel two cycles later.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, xfer};
    issue     = 1'b0;
    if (reset_n && !rd_done && (occupancy < 3'd2))
      issue = (state == st_stream) || ((state == st_idle) && start);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      st_idle:   if (start) state_nxt = st_stream;
      st_stream: begin
        if (xfer && xfer_eol) begin
          if (out_line == last_line) state_nxt = st_finish;
          else if (hblank > 0)       state_nxt = st_hblank;
        end
      end
      st_hblank: if (int'(hb_cnt) >= hblank - 1) state_nxt = st_stream;
      st_finish: state_nxt = st_idle;
      default:   state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= st_idle;
      rd_addr       <= '0;
      rd_done       <= 1'b0;
      rd_col        <= '0;
      rd_line       <= '0;
      in_flight     <= 1'b0;
      in_flight_tag <= 2'b00;
      out_line      <= '0;
      hb_cnt        <= '0;
    end else begin
      state     <= state_nxt;
      in_flight <= issue;
      if (issue) begin
        in_flight_tag <= {(rd_col == '0) && (rd_line == '0), rd_col == last_col};
        if (rd_addr == last_addr) rd_done <= 1'b1;
        else                      rd_addr <= rd_addr + addr_w'(1);
        if (rd_col == last_col) begin
          rd_col <= '0;
          if (rd_line != last_line) rd_line <= rd_line + line_w'(1);
        end else begin
          rd_col <= rd_col + col_w'(1);
        end
      end
      if (xfer && xfer_eol && (out_line != last_line))
        out_line <= out_line + line_w'(1);
      if (state == st_hblank) hb_cnt <= hb_cnt + hb_w'(1);
      else                    hb_cnt <= '0;
      // Frame complete: rewind everything so the next start reads from 0.
      if (state == st_finish) begin
        rd_addr  <= '0;
        rd_done  <= 1'b0;
        rd_col   <= '0;
        rd_line  <= '0;
        out_line <= '0;
      end
    end
  end

  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = rd_addr;
  assign bus.data      = fifo_head[pixel_width-1:0];
  assign bus.sof       = bus.enable && fifo_head[pixel_width+1];
  assign bus.eol       = bus.enable && fifo_head[pixel_width];
  assign busy          = (state != st_idle);
  assign done          = (state == st_finish);
  assign state_dbg     = state;

endmodule

// File: tb/tb_jmb_pixel_stream_src.sv
// Bench for jmb_pixel_stream_src: two instances (hblank=2 and hblank=0),
// random memory images and out_ready patterns checked against a raster model.
module tb_jmb_pixel_stream_src;
  import jmb_stream_pkg::*;

  localparam int pixel_width  = 8;
  localparam int image_width  = 10;
  localparam int image_height = 10;
  localparam int npix         = image_width * image_height;
  localparam int addr_w       = 7;
  localparam int hblank_a     = 2;

  logic clock;
  logic reset_n;
  logic [1:0] start_v, ready_v, en_v, sof_v, eol_v, busy_v, done_v, rd_v;
  logic [pixel_width-1:0] data_v [2];
  logic [addr_w-1:0] addr_v [2];
  state_t state_v [2];
  logic [pixel_width-1:0] mem [2][npix];
  int n_checks;
  int n_errors;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  jmb_pixel_stream_src_if #(.pixel_width(pixel_width), .addr_w(addr_w)) if_a ();
  jmb_pixel_stream_src_if #(.pixel_width(pixel_width), .addr_w(addr_w)) if_b ();

  jmb_pixel_stream_src #(.pixel_width(pixel_width), .image_width(image_width),
    .image_height(image_height), .hblank(hblank_a)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .state_dbg(state_v[0]), .bus(if_a));

  jmb_pixel_stream_src #(.pixel_width(pixel_width), .image_width(image_width),
    .image_height(image_height), .hblank(0)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .state_dbg(state_v[1]), .bus(if_b));

  assign if_a.out_ready = ready_v[0];
  assign if_b.out_ready = ready_v[1];
  assign en_v   = {if_b.enable, if_a.enable};
  assign sof_v  = {if_b.sof, if_a.sof};
  assign eol_v  = {if_b.eol, if_a.eol};
  assign rd_v   = {if_b.mem_rd_en, if_a.mem_rd_en};
  assign data_v[0] = if_a.data;
  assign data_v[1] = if_b.data;
  assign addr_v[0] = if_a.mem_addr;
  assign addr_v[1] = if_b.mem_addr;

  // Frame memory: read data valid one cycle after the strobe.
  always @(posedge clock) begin
    if (if_a.mem_rd_en) if_a.mem_data <= mem[0][if_a.mem_addr];
    if (if_b.mem_rd_en) if_b.mem_data <= mem[1][if_b.mem_addr];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_quiet(input int k);
    check("rst_enable", 32'(en_v[k]), 0);
    check("rst_sof", 32'(sof_v[k]), 0);
    check("rst_eol", 32'(eol_v[k]), 0);
    check("rst_busy", 32'(busy_v[k]), 0);
    check("rst_done", 32'(done_v[k]), 0);
    check("rst_rd_en", 32'(rd_v[k]), 0);
    check("rst_data", 32'(data_v[k]), 0);
    check("rst_addr", 32'(addr_v[k]), 0);
    check("rst_state", 32'(state_v[k]), 32'(st_idle));
  endtask

  // ---------------- driver ----------------
  task automatic fill_mem(input int k, input bit ramp);
    for (int i = 0; i < npix; i++)
      mem[k][i] = ramp ? pixel_width'(i) : pixel_width'($urandom_range(0, 255));
  endtask

  // mode: 0 ready always, 1 pattern 1,0,0,1, 2 random, 3 low for first 20 cycles
  task automatic run_frame(input int k, input int mode, input int restart_at, input int reset_at);
    int cyc = 0, xfers = 0, reads = 0, dones = 0, last_xfer = -1, done_cyc = -1, hb;
    logic [pixel_width+1:0] obs, expv, held;
    logic stalled = 1'b0, prev_eol = 1'b0, rdy, en;
    logic [pixel_width+1:0] exp_q[$];
    hb = (k == 0) ? hblank_a : 0;
    held = '0;
    for (int i = 0; i < npix; i++)
      exp_q.push_back({(i == 0), ((i % image_width) == image_width - 1), mem[k][i]});
    while (cyc < 600 && !(dones > 0 && cyc > done_cyc + 2)) begin
      @(negedge clock);
      en  = en_v[k];
      obs = {sof_v[k], eol_v[k], data_v[k]};
      if (reset_at >= 0 && xfers == reset_at) begin
        reset_n = 1'b0;
        #1;
        check_quiet(k);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        start_v[k] = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clock);
          check("post_rst_enable", 32'(en_v[k]), 0);
          check("post_rst_busy", 32'(busy_v[k]), 0);
        end
        return;
      end
      if (stalled) begin
        check("hold_enable", 32'(en), 1);
        check("hold_pixel", 32'(obs), 32'(held));
      end
      if (done_v[k]) begin
        dones++;
        done_cyc = cyc;
        check("done_after_last", cyc, last_xfer + 1);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = (cyc >= 20);
      endcase
      ready_v[k] = rdy;
      start_v[k] = (cyc == 0) || (restart_at >= 0 && xfers == restart_at && en);
      #1;
      if (rd_v[k]) begin
        check("mem_addr", 32'(addr_v[k]), reads);
        reads++;
      end
      if (mode == 3 && cyc == 19) check("reads_while_stalled", reads, 2);
      if (en && rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", xfers + 1, npix);
        end else begin
          expv = exp_q.pop_front();
          check("pixel", 32'(obs), 32'(expv));
        end
        if (mode == 0 && last_xfer >= 0) check("gap", cyc - last_xfer - 1, prev_eol ? hb : 0);
        if (mode == 0 && last_xfer < 0) check("first_enable", cyc, 2);
        prev_eol  = obs[pixel_width];
        last_xfer = cyc;
        xfers++;
      end
      stalled = en && !rdy;
      held    = obs;
      check("outstanding_le2", 32'((reads - xfers) <= 2), 1);
      cyc++;
    end
    start_v[k] = 1'b0;
    check("xfer_count", xfers, npix);
    check("done_count", dones, 1);
    check("busy_at_end", 32'(busy_v[k]), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    start_v  = 2'b00;
    ready_v  = 2'b00;
    fill_mem(0, 1'b1);
    fill_mem(1, 1'b1);
    repeat (3) @(negedge clock);
    check_quiet(0);
    check_quiet(1);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run_frame(0, 0, -1, -1);           // ramp image, full rate, hblank 2
    fill_mem(0, 1'b0);
    run_frame(0, 1, -1, -1);           // out_ready 1,0,0,1
    run_frame(0, 2, -1, -1);           // random out_ready
    fill_mem(1, 1'b0);
    run_frame(1, 0, -1, -1);           // hblank 0: no gaps
    run_frame(0, 0, 37, -1);           // start pulsed mid-frame
    run_frame(0, 0, -1, 55);           // reset mid-frame
    run_frame(0, 0, -1, -1);           // fresh frame after reset
    fill_mem(0, 1'b0);
    run_frame(0, 3, -1, -1);           // out_ready low for 20 cycles
    run_frame(1, 2, -1, -1);           // hblank 0 with random out_ready

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
